xp_input_vc_buffer: RTL and testbench

Receive-side input stage of a crosspoint (XP) router port. It sits directly downstream of an XP port link and accepts flits tagged with a virtual-channel ID into per-VC FIFOs. It arbitrates round-robin among non-empty VCs toward the XP switch and returns one credit per dequeued flit to the upstream sender. It also publishes the aggregate free-entry count used for flow control.

---
 rtl/xp_input_vc_buffer_if.sv | 41 ++++
 rtl/xp_input_vc_buffer.sv | 124 ++++++++++++
 tb/tb_xp_input_vc_buffer.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xp_input_vc_buffer_if.sv
// Flit type shared with the rest of the coherent NoC, and the handshake bundle
// between an XP port link / XP switch and the input VC buffer.
package coh_noc_pkg;
  typedef struct packed {
    logic [1:0]  kind;
    logic [29:0] data;
  } flit_t;
endpackage

interface xp_input_vc_buffer_if #(
  parameter int CNT_W = 5
);
  import coh_noc_pkg::*;

  logic             in_valid;
  logic             in_ready;
  flit_t            in_flit;
  logic [3:0]       in_vc_id;
  logic             out_valid;
  logic             out_ready;
  flit_t            out_flit;
  logic [3:0]       out_vc_id;
  logic             cred_ret_valid;
  logic [3:0]       cred_ret_vc;
  logic [CNT_W-1:0] credit_count;
  logic             err_bad_vc;

  // The buffer itself.
  modport slave (
    input  in_valid, in_flit, in_vc_id, out_ready,
    output in_ready, out_valid, out_flit, out_vc_id,
           cred_ret_valid, cred_ret_vc, credit_count, err_bad_vc
  );

  // Upstream link plus switch, seen as one driver.
  modport master (
    output in_valid, in_flit, in_vc_id, out_ready,
    input  in_ready, out_valid, out_flit, out_vc_id,
           cred_ret_valid, cred_ret_vc, credit_count, err_bad_vc
  );
endinterface

// File: rtl/xp_input_vc_buffer.sv
// XP router input stage: per-VC circular FIFOs, round-robin grant toward the
// switch with a stall lock, one credit returned per dequeued flit.
module xp_input_vc_buffer
  import coh_noc_pkg::*;
#(
  parameter int NUM_VC   = 4,
  parameter int VC_DEPTH = 4,
  parameter int CNT_W    = $clog2(NUM_VC*VC_DEPTH+1)
) (
  input logic                  clk,
  input logic                  rst_n,
  xp_input_vc_buffer_if.slave  bus
);

  localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int PTR_W = $clog2(VC_DEPTH);
  localparam int OCC_W = $clog2(VC_DEPTH+1);
  localparam int TOTAL = NUM_VC * VC_DEPTH;

  flit_t            mem    [NUM_VC][VC_DEPTH];
  logic [PTR_W-1:0] rd_ptr [NUM_VC];
  logic [PTR_W-1:0] wr_ptr [NUM_VC];
  logic [OCC_W-1:0] occ    [NUM_VC];

  logic [VC_W-1:0]  rr;
  logic [VC_W-1:0]  winner;
  logic [VC_W-1:0]  grant_vc;
  logic [VC_W-1:0]  lock_vc;
  logic [VC_W-1:0]  in_sel;
  logic             locked;
  logic             any_ne;
  logic             bad_vc;
  logic             enq;
  logic             deq;

  assign bad_vc = bus.in_vc_id >= 4'(NUM_VC);
  assign in_sel = bus.in_vc_id[VC_W-1:0];

  // A full VC refuses even when it is draining this cycle: no write-through.
  always_comb begin
    if (!rst_n)      bus.in_ready = 1'b0;
    else if (bad_vc) bus.in_ready = 1'b1;
    else             bus.in_ready = (occ[in_sel] != OCC_W'(VC_DEPTH));
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    int idx;
    winner = rr;
    any_ne = 1'b0;
    idx    = 0;
    // Walk from lowest priority to highest so the last hit is the winner.
    for (int i = NUM_VC - 1; i >= 0; i--) begin
      idx = (int'(rr) + i) % NUM_VC;
      if (occ[idx] != '0) begin
        winner = VC_W'(idx);
        any_ne = 1'b1;
      end
    end
  end

  assign grant_vc      = locked ? lock_vc : winner;
  assign bus.out_valid = any_ne || locked;
  assign bus.out_flit  = mem[grant_vc][rd_ptr[grant_vc]];
  assign bus.out_vc_id = 4'(grant_vc);

  assign deq = bus.out_valid && bus.out_ready;
  assign enq = bus.in_valid && bus.in_ready && !bad_vc;

  // NOTE: flit storage has no reset; stale entries are unreachable because
  // occupancy, not the data, decides what is visible.
  always_ff @(posedge clk) begin
    if (enq) mem[in_sel][wr_ptr[in_sel]] <= bus.in_flit;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // reader in this block sees the pre-edge value regardless of order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VC; v++) begin
        rd_ptr[v] <= '0;
        wr_ptr[v] <= '0;
        occ[v]    <= '0;
      end
      rr                 <= '0;
      locked             <= 1'b0;
      lock_vc            <= '0;
      bus.cred_ret_valid <= 1'b0;
      bus.cred_ret_vc    <= '0;
      bus.err_bad_vc     <= 1'b0;
      bus.credit_count   <= CNT_W'(TOTAL);
    end else begin
      if (enq) wr_ptr[in_sel] <= wr_ptr[in_sel] + 1'b1;
      if (deq) begin
        rd_ptr[grant_vc] <= rd_ptr[grant_vc] + 1'b1;
        rr <= (grant_vc == VC_W'(NUM_VC - 1)) ? '0 : grant_vc + 1'b1;
      end

      for (int v = 0; v < NUM_VC; v++) begin
        case ({enq && (in_sel == VC_W'(v)), deq && (grant_vc == VC_W'(v))})
          2'b10:   occ[v] <= occ[v] + 1'b1;
          2'b01:   occ[v] <= occ[v] - 1'b1;
          default: occ[v] <= occ[v];
        endcase
      end

      case ({enq, deq})
        2'b10:   bus.credit_count <= bus.credit_count - 1'b1;
        2'b01:   bus.credit_count <= bus.credit_count + 1'b1;
        default: bus.credit_count <= bus.credit_count;
      endcase

      // Hold the grant across a stall so the switch sees a stable head.
      locked  <= bus.out_valid && !bus.out_ready;
      lock_vc <= grant_vc;

      bus.cred_ret_valid <= deq;
      if (deq) bus.cred_ret_vc <= 4'(grant_vc);
      bus.err_bad_vc <= bus.in_valid && bad_vc;
    end
  end

endmodule

// File: tb/tb_xp_input_vc_buffer.sv
// Self-checking bench for xp_input_vc_buffer: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_xp_input_vc_buffer;
  import coh_noc_pkg::*;

  localparam int NUM_VC   = 4;
  localparam int VC_DEPTH = 4;
  localparam int CNT_W    = $clog2(NUM_VC*VC_DEPTH+1);
  localparam int TOTAL    = NUM_VC * VC_DEPTH;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  xp_input_vc_buffer_if #(.CNT_W(CNT_W)) bus ();

  xp_input_vc_buffer #(
    .NUM_VC(NUM_VC), .VC_DEPTH(VC_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one queue per VC plus the arbitration bookkeeping.
  flit_t q [NUM_VC][$];
  int    m_rr;
  bit    m_locked;
  int    m_lock_vc;
  bit    m_cred;
  int    m_cred_vc;
  bit    m_err;
  int    m_count;

  function automatic bit m_ready();
    if (!rst_n) return 1'b0;
    if (bus.in_vc_id >= NUM_VC) return 1'b1;
    return q[bus.in_vc_id].size() < VC_DEPTH;
  endfunction

  function automatic int m_grant();
    if (m_locked) return m_lock_vc;
    for (int i = 0; i < NUM_VC; i++)
      if (q[(m_rr + i) % NUM_VC].size() > 0) return (m_rr + i) % NUM_VC;
    return -1;
  endfunction

  task automatic model_edge();
    int  g;
    bit  rdy;
    bit  dq;
    if (!rst_n) begin
      for (int v = 0; v < NUM_VC; v++) q[v].delete();
      m_rr = 0; m_locked = 0; m_lock_vc = 0;
      m_cred = 0; m_cred_vc = 0; m_err = 0; m_count = TOTAL;
      return;
    end
    g   = m_grant();
    rdy = m_ready();
    dq  = (g >= 0) && bus.out_ready;
    if (dq) begin
      void'(q[g].pop_front());
      m_rr = (g + 1) % NUM_VC;
    end
    if (bus.in_valid && rdy && bus.in_vc_id < NUM_VC)
      q[bus.in_vc_id].push_back(bus.in_flit);
    m_cred = dq;
    if (dq) m_cred_vc = g;
    m_err     = bus.in_valid && (bus.in_vc_id >= NUM_VC);
    m_locked  = (g >= 0) && !bus.out_ready;
    m_lock_vc = g;
    m_count   = TOTAL;
    for (int v = 0; v < NUM_VC; v++) m_count -= q[v].size();
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int vc, output flit_t f);
    f = flit_t'($urandom);
    bus.in_valid = 1'b1;
    bus.in_vc_id = 4'(vc);
    bus.in_flit  = f;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_vc_id = '0; bus.in_flit = '0; bus.out_ready = 1'b0;
    tick(); tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++;
      $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
    checks++; if (bus.cred_ret_valid !== 1'b0) begin errors++;
      $display("FAIL reset_cred got %0b want 0", bus.cred_ret_valid); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++;
      $display("FAIL reset_in_ready got %0b want 0", bus.in_ready); end
    checks++; if (bus.credit_count !== CNT_W'(TOTAL)) begin errors++;
      $display("FAIL reset_count got %0d want %0d", bus.credit_count, TOTAL); end
    rst_n = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++;
      $display("FAIL release_in_ready got %0b want 1", bus.in_ready); end
  endtask

  task automatic test_fill_vc(output flit_t f0);
    flit_t f;
    bus.out_ready = 1'b0;
    push(2, f0);
    for (int i = 1; i < VC_DEPTH; i++) push(2, f);
    bus.in_vc_id = 4'd2; #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++;
      $display("FAIL full_vc2_ready got %0b want 0", bus.in_ready); end
    bus.in_vc_id = 4'd0; #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++;
      $display("FAIL vc0_ready got %0b want 1", bus.in_ready); end
    checks++; if (bus.credit_count !== CNT_W'(TOTAL - VC_DEPTH)) begin errors++;
      $display("FAIL fill_count got %0d want %0d", bus.credit_count, TOTAL - VC_DEPTH); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.out_vc_id !== 4'd2 || bus.out_flit !== f0) begin errors++;
        $display("FAIL stall_stable vc %0d flit %h want vc 2 flit %h",
                 bus.out_vc_id, bus.out_flit, f0); end
      tick();
    end
  endtask

  task automatic test_full_boundary(input flit_t f0);
    bus.in_valid = 1'b1; bus.in_vc_id = 4'd2; bus.in_flit = flit_t'($urandom);
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++;
      $display("FAIL full_deq_ready got %0b want 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_flit !== f0) begin errors++;
      $display("FAIL full_head valid %0b flit %h want 1 %h", bus.out_valid, bus.out_flit, f0); end
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++;
      $display("FAIL after_deq_ready got %0b want 1", bus.in_ready); end
    checks++; if (bus.cred_ret_valid !== 1'b1 || bus.cred_ret_vc !== 4'd2) begin errors++;
      $display("FAIL full_cred valid %0b vc %0d want 1 2", bus.cred_ret_valid, bus.cred_ret_vc); end
    for (int i = 0; i < VC_DEPTH - 1; i++) begin
      checks++; if (bus.out_vc_id !== 4'd2 || bus.out_flit !== q[2][0]) begin errors++;
        $display("FAIL drain_vc2 vc %0d flit %h want 2 %h", bus.out_vc_id, bus.out_flit, q[2][0]); end
      tick();
    end
    checks++; if (bus.out_valid !== 1'b0 || bus.credit_count !== CNT_W'(TOTAL)) begin errors++;
      $display("FAIL drained valid %0b count %0d want 0 %0d", bus.out_valid, bus.credit_count, TOTAL); end
  endtask

  task automatic test_round_robin();
    flit_t f;
    int    order [3];
    order = '{0, 1, 3};
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    bus.out_ready = 1'b0;
    foreach (order[k]) push(order[k], f);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (bus.out_vc_id !== 4'(order[k])) begin errors++;
        $display("FAIL rr_order[%0d] got %0d want %0d", k, bus.out_vc_id, order[k]); end
      if (k > 0) begin
        checks++; if (bus.cred_ret_valid !== 1'b1 || bus.cred_ret_vc !== 4'(order[k-1])) begin
          errors++;
          $display("FAIL rr_cred[%0d] valid %0b vc %0d want 1 %0d",
                   k - 1, bus.cred_ret_valid, bus.cred_ret_vc, order[k-1]); end
      end
      tick();
    end
    checks++; if (bus.cred_ret_valid !== 1'b1 || bus.cred_ret_vc !== 4'd3 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rr_last_cred valid %0b vc %0d out_valid %0b want 1 3 0",
               bus.cred_ret_valid, bus.cred_ret_vc, bus.out_valid); end
    bus.out_ready = 1'b0;
    push(0, f);
    push(3, f);
    checks++; if (bus.out_vc_id !== 4'd0) begin errors++;
      $display("FAIL rr_vc0_wins got %0d want 0", bus.out_vc_id); end
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.out_vc_id !== 4'd3 || bus.out_valid !== 1'b1) begin errors++;
      $display("FAIL rr_then_vc3 vc %0d valid %0b want 3 1", bus.out_vc_id, bus.out_valid); end
    tick();
  endtask

  task automatic test_illegal_vc();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_vc_id = 4'd5; bus.in_flit = flit_t'($urandom);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++;
      $display("FAIL bad_vc_ready got %0b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.err_bad_vc !== 1'b1) begin errors++;
      $display("FAIL bad_vc_err got %0b want 1", bus.err_bad_vc); end
    checks++; if (bus.credit_count !== CNT_W'(TOTAL) || bus.out_valid !== 1'b0) begin errors++;
      $display("FAIL bad_vc_state count %0d valid %0b want %0d 0",
               bus.credit_count, bus.out_valid, TOTAL); end
    tick();
    checks++; if (bus.err_bad_vc !== 1'b0) begin errors++;
      $display("FAIL bad_vc_pulse got %0b want 0", bus.err_bad_vc); end
  endtask

  task automatic test_random();
    int g;
    for (int n = 0; n < 600; n++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_vc_id  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15))
                                                  : 4'($urandom_range(0, 3));
      bus.in_flit   = flit_t'($urandom);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      #1;
      g = m_grant();
      checks++; if (bus.in_ready !== m_ready()) begin errors++;
        $display("FAIL rnd_in_ready[%0d] got %0b want %0b", n, bus.in_ready, m_ready()); end
      checks++; if (bus.out_valid !== (g >= 0)) begin errors++;
        $display("FAIL rnd_out_valid[%0d] got %0b want %0b", n, bus.out_valid, g >= 0); end
      if (g >= 0) begin
        checks++; if (bus.out_vc_id !== 4'(g) || bus.out_flit !== q[g][0]) begin errors++;
          $display("FAIL rnd_head[%0d] vc %0d flit %h want %0d %h",
                   n, bus.out_vc_id, bus.out_flit, g, q[g][0]); end
      end
      checks++; if (bus.cred_ret_valid !== m_cred) begin errors++;
        $display("FAIL rnd_cred[%0d] got %0b want %0b", n, bus.cred_ret_valid, m_cred); end
      if (m_cred) begin
        checks++; if (bus.cred_ret_vc !== 4'(m_cred_vc)) begin errors++;
          $display("FAIL rnd_cred_vc[%0d] got %0d want %0d", n, bus.cred_ret_vc, m_cred_vc); end
      end
      checks++; if (bus.err_bad_vc !== m_err) begin errors++;
        $display("FAIL rnd_err[%0d] got %0b want %0b", n, bus.err_bad_vc, m_err); end
      checks++; if (bus.credit_count !== CNT_W'(m_count)) begin errors++;
        $display("FAIL rnd_count[%0d] got %0d want %0d", n, bus.credit_count, m_count); end
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    flit_t f;
    bus.out_ready = 1'b0;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int v = 0; v < 3; v++) push(v, f);
    #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.credit_count !== CNT_W'(TOTAL - 3)) begin errors++;
      $display("FAIL mid_pre valid %0b count %0d want 1 %0d",
               bus.out_valid, bus.credit_count, TOTAL - 3); end
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.credit_count !== CNT_W'(TOTAL) ||
                  bus.cred_ret_valid !== 1'b0) begin errors++;
      $display("FAIL mid_reset valid %0b count %0d cred %0b want 0 %0d 0",
               bus.out_valid, bus.credit_count, bus.cred_ret_valid, TOTAL); end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.cred_ret_valid !== 1'b0 || bus.out_valid !== 1'b0) begin errors++;
        $display("FAIL mid_after[%0d] cred %0b valid %0b want 0 0",
                 i, bus.cred_ret_valid, bus.out_valid); end
    end
  endtask

  initial begin
    flit_t f0;
    checks = 0;
    errors = 0;
    test_reset();
    test_fill_vc(f0);
    test_full_boundary(f0);
    test_round_robin();
    test_illegal_vc();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
